// File: rtl/gray_to_binary_tracker_pkg.sv
`default_nettype none
// ============================================================================
// Module   : gray_pkg
// Purpose  : Shared types and constants for the Gray-coded position tracker:
//            FSM state type, event record, reference Gray decode function and
//            the "down step" delta constant.
// Revision : 1.0  initial release
// ============================================================================
package gray_pkg;

    // Width of the Gray bus the event record is sized for. The tracker's W
    // parameter must be overridden together with this value.
    localparam int GRAY_W = 4;

    // A -1 step modulo 2^W shows up as an all-ones delta.
    localparam logic [GRAY_W-1:0] DELTA_DN = '1;

    typedef enum logic [1:0] {
        INIT = 2'd0,
        IDLE = 2'd1,
        PEND = 2'd2
    } state_t;

    typedef struct packed {
        logic [GRAY_W-1:0] bin;
        logic              dir_up;
        logic              step_err;
        logic              ovr;
    } event_rec_t;

    // Prefix-XOR Gray to binary conversion: each binary bit is the XOR of all
    // Gray bits at or above its position.
    function automatic logic [GRAY_W-1:0] gray2bin(input logic [GRAY_W-1:0] g);
        logic [GRAY_W-1:0] b;
        b[GRAY_W-1] = g[GRAY_W-1];
        for (int i = GRAY_W - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage : gray_pkg
`default_nettype wire

// File: rtl/gray_to_binary_tracker_dec.sv
`default_nettype none
// ============================================================================
// Module   : gray_to_binary
// Purpose  : Purely combinational W-bit Gray to binary decoder. Each output
//            bit is the XOR reduction of the Gray bits from its position up
//            to the MSB, so no bit depends on another output bit.
// Revision : 1.0  initial release
// ============================================================================
module gray_to_binary #(
    parameter int W = 4
) (
    input  logic [W-1:0] i_gray,
    output logic [W-1:0] o_bin
);

    genvar i;
    generate
        for (i = 0; i < W; i++) begin : g_bit
            assign o_bin[i] = ^i_gray[W-1:i];
        end
    endgenerate

endmodule : gray_to_binary
`default_nettype wire

// File: rtl/gray_to_binary_tracker.sv
`default_nettype none
// ============================================================================
// Module   : gray_to_binary_tracker
// Purpose  : Receive side of a Gray-coded position interface. Captures (and
//            optionally synchronises) a Gray bus, decodes it, classifies each
//            change as +1 / -1 / illegal jump, keeps a wrapping position
//            count and hands one event record per change downstream over a
//            valid/ready handshake.
// Options  : GRAY_SYNC_EN - when defined, a two-flop synchroniser sits ahead
//            of the capture register (gray_in may be asynchronous, latency 3
//            edges). Undefined: single capture flop, latency 2 edges.
// Revision : 1.0  initial release
// ============================================================================
import gray_pkg::*;

module gray_to_binary_tracker #(
    parameter int W  = GRAY_W,
    parameter int CW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [W-1:0]  gray_in,
    output logic [W-1:0]  bin_out,
    output logic          dir_up,
    output logic          step_err,
    output logic          ovr,
    output logic          bin_valid,
    input  logic          bin_ready,
    output logic [CW-1:0] pos_cnt
);

    localparam logic [W-1:0]  c_delta_up = {{(W-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0] c_pos_one  = {{(CW-1){1'b0}}, 1'b1};

    logic [W-1:0]  r_g_q;
    logic [W-1:0]  w_bin;
    logic [W-1:0]  w_delta;
    logic          w_event;
    logic          w_up;
    logic          w_dn;
    logic          w_err;

    state_t        r_state;
    logic [W-1:0]  r_prev_bin;
    event_rec_t    r_rec;
    logic          r_valid;
    logic [CW-1:0] r_pos;

    // ------------------------------------------------------------------
    // Capture path. These flops carry no reset on purpose: they keep
    // sampling the bus while rst_n is low, so the INIT state sees the live
    // position on the first clock after release instead of a stale zero.
    // ------------------------------------------------------------------
`ifdef GRAY_SYNC_EN
    logic [W-1:0] r_sync1;

    // Two-flop synchroniser for an asynchronous Gray bus.
    always_ff @(posedge clk) begin
        r_sync1 <= gray_in;
        r_g_q   <= r_sync1;
    end
`else
    // Single capture flop; gray_in is expected to be synchronous to clk.
    always_ff @(posedge clk) begin
        r_g_q <= gray_in;
    end
`endif

    gray_to_binary #(
        .W (W)
    ) u_dec (
        .i_gray (r_g_q),
        .o_bin  (w_bin)
    );

    // Classify the change against the last position that produced an event.
    always_comb begin
        w_delta = w_bin - r_prev_bin;
        w_event = (r_state != INIT) && (w_delta != '0);
        w_up    = (w_delta == c_delta_up);
        w_dn    = (w_delta == DELTA_DN);
        w_err   = !w_up && !w_dn;
    end

    // Handshake FSM: loads, overwrites and retires the event record.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= INIT;
            r_prev_bin <= '0;
            r_rec      <= '0;
            r_valid    <= 1'b0;
        end else begin
            case (r_state)
                INIT: begin
                    r_prev_bin <= w_bin;
                    r_state    <= IDLE;
                end
                IDLE: begin
                    if (w_event) begin
                        r_prev_bin <= w_bin;
                        r_rec      <= '{bin: w_bin, dir_up: w_up, step_err: w_err, ovr: 1'b0};
                        r_valid    <= 1'b1;
                        r_state    <= PEND;
                    end
                end
                PEND: begin
                    if (w_event) begin
                        // Overwrite flag only when the held record was not taken.
                        r_prev_bin <= w_bin;
                        r_rec      <= '{bin: w_bin, dir_up: w_up, step_err: w_err, ovr: !bin_ready};
                    end else if (bin_ready) begin
                        r_valid <= 1'b0;
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_state <= INIT;
                    r_valid <= 1'b0;
                end
            endcase
        end
    end

    // Position counter follows every legal step, regardless of backpressure.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pos <= '0;
        end else if (w_event) begin
            if (w_up) begin
                r_pos <= r_pos + c_pos_one;
            end else if (w_dn) begin
                r_pos <= r_pos - c_pos_one;
            end
        end
    end

    assign bin_out   = r_rec.bin;
    assign dir_up    = r_rec.dir_up;
    assign step_err  = r_rec.step_err;
    assign ovr       = r_rec.ovr;
    assign bin_valid = r_valid;
    assign pos_cnt   = r_pos;

endmodule : gray_to_binary_tracker
`default_nettype wire
